// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default line parameters,
// common to the transmitter and receiver.
package uart_pkg;

  localparam int unsigned ClkFreqDefault  = 10000;
  localparam int unsigned BaudRateDefault = 1000;
  localparam int unsigned DataSizeDefault = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StStart  = 3'b001,
    StData   = 3'b010,
    StStop   = 3'b011,
    StParity = 3'b100
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-clock tick every DIV clocks, restartable so bit
// boundaries can be aligned to the start of a frame.
module uart_baud_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = $clog2(DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: inline FIFO feeding a start/data/parity/stop
// framer with a registered serial output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = ClkFreqDefault,
  parameter int unsigned BAUD_RATE  = BaudRateDefault,
  parameter int unsigned DATA_SIZE  = DataSizeDefault,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_SIZE-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned Div  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned BitW = $clog2(DATA_SIZE + 1);

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 push, pop, fifo_empty;

  uart_state_e          state_q, state_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 baud_restart, baud_tick;

  assign in_ready   = (count_q != (PtrW + 1)'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count_q == '0);
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign busy       = (state_q != StIdle);

  uart_baud_gen #(
    .DIV (Div)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (baud_restart),
    .tick    (baud_tick)
  );

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    bit_cnt_d    = bit_cnt_q;
    pop          = 1'b0;
    baud_restart = 1'b0;

    case (state_q)
      StIdle: begin
        baud_restart = 1'b1;
        pop          = !fifo_empty;
      end
      StStart: begin
        if (baud_tick) state_d = StData;
      end
      StData: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BitW'(DATA_SIZE - 1)) begin
            state_d = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (baud_tick) state_d = StStop;
      end
      StStop: begin
        if (baud_tick) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Loading a byte always begins a fresh, DIV-aligned frame.
    if (pop) begin
      state_d      = StStart;
      shift_d      = mem_q[rd_ptr_q];
      parity_d     = (^mem_q[rd_ptr_q]) ^ (PARITY_ODD != 0);
      bit_cnt_d    = '0;
      baud_restart = 1'b1;
    end
  end

  always_comb begin
    case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
      StParity: tx_d = parity_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: frame-level reference model checked every cycle,
// a behavioural line receiver, and literal checks of hand-computed waveforms.
module tb_uart_tx;

  localparam int DIV   = 10;
  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = (N + 3) * DIV;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, tx, busy;
  logic [2:0]   fifo_count;

  logic         odd_valid = 1'b0;
  logic         odd_ready, odd_tx, odd_busy;
  logic [2:0]   odd_count;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  uart_tx #(
    .PARITY_ODD (1)
  ) dut_odd (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (odd_valid),
    .in_ready   (odd_ready),
    .tx         (odd_tx),
    .busy       (odd_busy),
    .fifo_count (odd_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: queued bytes plus the frame currently on the line.
  logic [N-1:0] mq[$];
  logic [N-1:0] sent_q[$];
  logic [N-1:0] m_byte;
  logic         m_act = 1'b0;
  int           m_t = 0;
  logic         m_tx = 1'b1;
  logic         m_push = 1'b0;

  logic         tx_log[$];
  logic         odd_log[$];

  // Behavioural receiver state.
  logic         rx_on = 1'b0;
  int           rx_t = 0;
  logic         rx_bits [N+3];
  logic         prev_tx = 1'b1;
  logic         prev_busy = 1'b0;
  int           rises = 0;
  int           frames = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic par_of(input logic [N-1:0] b, input int odd);
    return logic'($countones(b) % 2) ^ (odd != 0);
  endfunction

  function automatic logic frame_bit(input logic [N-1:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= N) return b[i-1];
    if (i == N + 1) return par_of(b, 0);
    return 1'b1;
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic [N-1:0] d);
    int pre_size;
    if (!r) begin
      mq.delete();
      sent_q.delete();
      m_act  = 1'b0;
      m_t    = 0;
      m_tx   = 1'b1;
      m_push = 1'b0;
      return;
    end
    m_tx     = m_act ? frame_bit(m_byte, m_t / DIV) : 1'b1;
    m_push   = v && (mq.size() < DEPTH);
    pre_size = mq.size();
    if (m_act) begin
      m_t++;
      if (m_t == FRAME) m_act = 1'b0;
    end
    if (!m_act && pre_size > 0) begin
      m_byte = mq.pop_front();
      m_act  = 1'b1;
      m_t    = 0;
      sent_q.push_back(m_byte);
    end
    if (m_push) mq.push_back(d);
  endtask

  task automatic rx_step(input logic r);
    logic [N-1:0] got;
    logic [N-1:0] exp;
    if (!r) begin
      rx_on = 1'b0;
    end else if (rx_on) begin
      rx_t++;
      if (rx_t % DIV == DIV / 2) begin
        rx_bits[rx_t / DIV] = tx;
        if (rx_t / DIV == N + 2) begin
          rx_on = 1'b0;
          frames++;
          for (int i = 0; i < N; i++) got[i] = rx_bits[i+1];
          chk("rx_start", int'(rx_bits[0]), 0);
          chk("rx_stop", int'(rx_bits[N+2]), 1);
          if (sent_q.size() == 0) begin
            chk("rx_unexpected_frame", 1, 0);
          end else begin
            exp = sent_q.pop_front();
            chk("rx_data", int'(got), int'(exp));
            chk("rx_parity", int'(rx_bits[N+1]), int'(par_of(exp, 0)));
          end
        end
      end
    end else if (!tx && prev_tx) begin
      rx_on = 1'b1;
      rx_t  = 0;
    end
  endtask

  // One clock: drive, let the edge happen, update the model, compare at negedge.
  task automatic cycle(input logic v, input logic [N-1:0] d, input logic r);
    in_valid = v;
    in_data  = d;
    reset    = r;
    @(posedge clk);
    model_edge(r, v, d);
    @(negedge clk);
    chk("tx", int'(tx), int'(m_tx));
    chk("busy", int'(busy), int'(m_act));
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
    tx_log.push_back(tx);
    odd_log.push_back(odd_tx);
    rx_step(r);
    if (busy && !prev_busy) rises++;
    prev_busy = busy;
    prev_tx   = tx;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
  endtask

  task automatic push_byte(input logic [N-1:0] d, output int tries);
    tries = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      cycle(1'b1, d, 1'b1);
      tries++;
      if (m_push) return;
    end
    chk("push_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < (DEPTH + 2) * FRAME; i++) begin
      if (!m_act && mq.size() == 0 && !rx_on) return;
      cycle(1'b0, '0, 1'b1);
    end
    chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, e, tries, zeros;
    logic a5_bits [11];
    a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_fifo_count", int'(fifo_count), 0);
    idle(3);

    // 0xA5 frame waveform.
    c0 = cyc;
    cycle(1'b1, 8'hA5, 1'b1);
    idle(FRAME + 10);
    chk("a5_tx_after_1", int'(tx_log[c0+1]), 1);
    chk("a5_tx_after_2", int'(tx_log[c0+2]), 0);
    for (int b = 0; b < 11; b++) chk("a5_bit", int'(tx_log[c0+2+b*DIV+DIV/2]), int'(a5_bits[b]));
    chk("a5_last_stop_clk", int'(tx_log[c0+2+FRAME-1]), 1);
    chk("a5_bit_edge", int'(tx_log[c0+2+DIV]), 1);
    chk("a5_bit_edge_prev", int'(tx_log[c0+2+DIV-1]), 0);

    // 0x07 parity, even and odd.
    c1 = cyc;
    odd_valid = 1'b1;
    cycle(1'b1, 8'h07, 1'b1);
    odd_valid = 1'b0;
    idle(FRAME + 10);
    chk("p07_even", int'(tx_log[c1+2+(N+1)*DIV+DIV/2]), 1);
    chk("p07_odd", int'(odd_log[c1+2+(N+1)*DIV+DIV/2]), 0);
    chk("p07_odd_start", int'(odd_log[c1+2]), 0);

    // Burst of 5 while a frame is on the line.
    push_byte(8'h11, tries);
    idle(3);
    push_byte(8'h21, tries);
    push_byte(8'h32, tries);
    push_byte(8'h43, tries);
    push_byte(8'h54, tries);
    chk("burst_full_count", int'(fifo_count), 4);
    chk("burst_full_ready", int'(in_ready), 0);
    push_byte(8'h65, tries);
    chk("burst_fifth_wait", tries, 105);
    wait_idle();

    // Push on the same edge as the stop-end pop with one byte queued.
    push_byte(8'h3C, tries);
    idle(3);
    push_byte(8'hC3, tries);
    for (int i = 0; i < FRAME && !(m_act && m_t == FRAME - 1); i++) idle(1);
    e = cyc;
    cycle(1'b1, 8'h5A, 1'b1);
    chk("pushpop_count", int'(fifo_count), 1);
    chk("pushpop_busy", int'(busy), 1);
    idle(1);
    chk("pushpop_no_gap", int'(tx_log[e+1]), 0);
    wait_idle();

    // Reset during data bit 3 with a byte still queued.
    push_byte(8'hF0, tries);
    push_byte(8'h0F, tries);
    for (int i = 0; i < FRAME && !(m_act && m_t == 4 * DIV + 4); i++) idle(1);
    cycle(1'b0, '0, 1'b0);
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(fifo_count), 0);
    c0 = cyc;
    idle(2 * FRAME);
    zeros = 0;
    for (int i = c0; i < cyc; i++) if (!tx_log[i]) zeros++;
    chk("midrst_line_idle", zeros, 0);

    // Random bytes, one frame at a time, so busy rises once per frame.
    rises  = 0;
    frames = 0;
    for (int k = 0; k < 16; k++) begin
      push_byte(N'($urandom), tries);
      wait_idle();
      idle($urandom_range(0, 5));
    end
    chk("rand_busy_rises", rises, 16);
    chk("rand_frames", frames, 16);

    // Random valid traffic to exercise full/empty and pointer wrap.
    for (int k = 0; k < 600; k++) cycle(($urandom % 4) == 0, N'($urandom), 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, 10000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, 1000, line bit rate; DIV = CLK_FREQ/BAUD_RATE clocks per bit (default 10, SHALL be >= 4).
REQ-003 Parameter DATA_SIZE, 8, payload bits per frame (1..10).
REQ-004 Parameter PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
REQ-005 Parameter FIFO_DEPTH, 4, transmit buffer entries (power of two).
REQ-006 clk  input  1  clock, rising-edge active.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 in_data  input  DATA_SIZE  byte to transmit.
REQ-009 in_valid  input  1  in_data is valid this cycle.
REQ-010 in_ready  output  1  buffer can accept a byte (= not full).
REQ-011 tx  output  1  serial line, idle high.
REQ-012 busy  output  1  a frame is on the line.
REQ-013 fifo_count  output  clog2(FIFO_DEPTH)+1  number of bytes buffered.

Function
REQ-014 A byte SHALL be accepted on the rising edge where in_valid && in_ready; in_data is ignored otherwise.
REQ-015 in_ready SHALL be low exactly when fifo_count == FIFO_DEPTH; a write while full is dropped, and the count stays unchanged.
REQ-016 A push and a pop in the same cycle SHALL leave fifo_count unchanged; the read and write pointers wrap modulo FIFO_DEPTH.
REQ-017 Frame, LSB first: start (0), DATA_SIZE data bits, parity bit, stop (1). Each bit SHALL be held exactly DIV clocks, so a frame is (DATA_SIZE+3)*DIV clocks.
REQ-018 The parity bit SHALL be the XOR of the data bits (even), inverted when PARITY_ODD = 1.
REQ-019 FSM states are IDLE, START, DATA, PARITY and STOP.
REQ-020 In IDLE with fifo_count > 0, the FSM SHALL pop one byte into the shift register and enter START.
REQ-021 START, DATA (DATA_SIZE bit periods), PARITY and STOP each advance on the baud tick at the end of their bit period.
REQ-022 At the end of STOP, the FSM SHALL go directly to START if fifo_count > 0 (pop on that edge, no idle gap); otherwise it goes to IDLE.
REQ-023 The baud counter SHALL restart at 0 on entry to START, so every bit boundary is DIV-aligned to the frame start.
REQ-024 tx SHALL be registered. With an empty buffer and the FSM in IDLE, tx falls 2 clocks after the accepting edge.
REQ-025 busy SHALL be high in START, DATA, PARITY and STOP, and low in IDLE.
REQ-026 Writes SHALL be accepted during transmission; a pop and a push in the same cycle obey REQ-016.

Reset
REQ-027 While reset = 0 at a rising edge: tx = 1, busy = 0, in_ready = 1, fifo_count = 0, state = IDLE, baud counter = 0, pointers = 0.
REQ-028 Reset mid-frame SHALL abort the frame and flush the buffer. tx returns high on the next edge, and no partial frame resumes after reset.

Structure
REQ-029 Package uart_pkg SHALL hold the state encodings (IDLE=000, START=001, DATA=010, STOP=011, PARITY=100), the DATA_SIZE default and the CLK_FREQ/BAUD_RATE defaults, shared with the receiver.
REQ-030 Sub-module uart_baud_gen SHALL produce a one-clock tick every DIV clocks and support a synchronous restart input.
REQ-031 The FIFO SHALL be inline: a register array with pointers and a count.

Verification
REQ-032 Write 0xA5 after reset -> tx low 2 clocks later, then bits 1,0,1,0,0,1,0,1, parity 0, stop 1, each 10 clocks; frame length 110 clocks.
REQ-033 Write 0x07 with PARITY_ODD = 1 -> parity bit 0; with PARITY_ODD = 0 -> parity bit 1.
REQ-034 Burst-write 5 bytes with in_valid held high -> 4 accepted, in_ready low at count 4, the 5th accepted once the first pop occurs; the frames are back-to-back with no idle clock.
REQ-035 Push on the same edge as the STOP-end pop at count 1 -> fifo_count stays 1 and the next frame starts immediately.
REQ-036 Assert reset during DATA bit 3 -> next edge tx = 1, busy = 0, fifo_count = 0; after release, line idle until a new write.
REQ-037 Loopback of tx into the existing receiver over 16 random bytes -> received data and parity match the sent values, and busy toggles once per frame.
